program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, program address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (>=1).
REQ-003 SHALL have parameter NUM_CH, default 4, ready channels (>=1); CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ready_in  input  NUM_CH  external handshake lines.
REQ-007 SHALL have port op  input  3  sequencing command for the current instruction.
REQ-008 SHALL have port target  input  ADDR_WIDTH  jump/branch/call destination.
REQ-009 SHALL have port cond  input  1  branch condition (e.g. ALU flag).
REQ-010 SHALL have port ch_sel  input  CH_W  channel tested by WAIT.
REQ-011 SHALL have port wait_level  input  1  WAIT mode: 0 edge, 1 level.
REQ-012 SHALL have port wait_inv  input  1  WAIT polarity invert.
REQ-013 SHALL have port pc  output  ADDR_WIDTH  current program address (registered).
REQ-014 SHALL have port stalled  output  1  pc will not advance this cycle (combinational).
REQ-015 SHALL have port halted  output  1  FSM in HALTED (registered).
REQ-016 SHALL have port stack_cnt  output  clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-017 SHALL have ports err_ovf, err_unf  output  1 each  sticky stack overflow/underflow flags.

Function
REQ-018 SHALL implement FSM RUN/HALTED; HALTED left only by reset; in HALTED pc, stack, flags hold and op is ignored.
REQ-019 In RUN, op SHALL be decoded each cycle; next pc takes effect at the following rising edge (1-cycle latency).
REQ-020 op 000 NEXT: pc <= pc+1, modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-1 wraps to 0).
REQ-021 op 001 JUMP: pc <= target.
REQ-022 op 010 BRANCH: pc <= target if cond=1, else pc+1.
REQ-023 op 011 CALL: if stack_cnt<STACK_DEPTH, push (pc+1 wrapped), pc <= target; if full, no push, pc <= pc+1, err_ovf <= 1.
REQ-024 op 100 RET: if stack_cnt>0, pop, pc <= popped value; if empty, pc <= pc+1, err_unf <= 1.
REQ-025 op 101 WAIT: pc holds while not satisfied; pc <= pc+1 on the cycle satisfied (no extra cycle).
REQ-026 WAIT level mode: satisfied = ready_in[ch_sel] XOR wait_inv.
REQ-027 WAIT edge mode: per-channel registered sample prev; satisfied = rising edge (cur&~prev) if wait_inv=0, falling edge (~cur&prev) if wait_inv=1.
REQ-028 prev SHALL sample all channels every cycle regardless of op or FSM state.
REQ-029 ch_sel >= NUM_CH: channel value reads 0, edges never occur.
REQ-030 op 110 HALT: FSM -> HALTED next edge, pc holds.
REQ-031 op 111 reserved: behaves as NEXT.
REQ-032 stalled = 1 when HALTED, or RUN with op HALT, or RUN with op WAIT and not satisfied; else 0.
REQ-033 Stack is LIFO; push and pop never in same cycle; stack_cnt updates with pc.
REQ-034 err_ovf/err_unf SHALL stay set until reset; neither blocks further sequencing.

Reset
REQ-035 On reset=1 at a rising edge: pc=0, FSM=RUN, stack_cnt=0, err_ovf=0, err_unf=0, halted=0, prev=all 0; reset has priority over every op, including mid-WAIT and HALTED.
REQ-036 After release, a channel already high yields a rising edge on the first cycle (prev=0).

Verification
REQ-037 NEXT x16 from pc=0, ADDR_WIDTH=4 -> pc 1..15, then 0; stalled=0 throughout.
REQ-038 pc=3 CALL target=9, then RET -> pc 9, stack_cnt 1, then pc 4, stack_cnt 0.
REQ-039 Five CALLs (depth 4) then RET with empty stack after four pops -> err_ovf=1 after 5th CALL (pc=target_4+1), err_unf=1 on 5th RET, pc advances by 1.
REQ-040 pc=5 WAIT edge, ch_sel=2, ready_in[2] held high 3 cycles then low then high -> pc holds at 5, stalled=1 until the low->high cycle, pc=6 next edge; level mode wait_inv=1 with ready_in[2]=0 -> pc=6 immediately.
REQ-041 BRANCH target=12 with cond=0 then cond=1 at pc=7 -> pc 8, then 12.
REQ-042 HALT at pc=4, drive JUMP target=1 for 5 cycles, then reset -> pc stays 4, halted=1, stalled=1; after reset pc=0, halted=0, flags 0.

Source files
------------

// File: rtl/program_sequencer.sv
// Program sequencer: generates the program address for a small controller.
//
// Each RUN cycle the sequencing command `op` picks the next pc. The choices are
// NEXT, JUMP, BRANCH, CALL, RET, WAIT on a ready channel, and HALT. CALL and RET
// use a LIFO return stack. HALT parks the FSM until reset.
//
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   ready_in[NUM_CH]    external handshake lines (edge-sampled every cycle)
//   op[2:0]             command: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET,
//                       5 WAIT, 6 HALT, 7 reserved (acts as NEXT)
//   target              jump/branch/call destination
//   cond                branch condition
//   ch_sel              channel tested by WAIT
//   wait_level          WAIT mode: 0 edge, 1 level
//   wait_inv            WAIT polarity invert
//   pc                  current program address (registered)
//   stalled             pc will not advance this cycle (combinational)
//   halted              FSM is in HALTED (registered)
//   stack_cnt           occupied return-stack entries
//   err_ovf, err_unf    sticky stack overflow / underflow flags
module program_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned NUM_CH      = 4,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ready_in,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] target,
  input  logic                  cond,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic                  wait_level,
  input  logic                  wait_inv,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  stalled,
  output logic                  halted,
  output logic [CNT_W-1:0]      stack_cnt,
  output logic                  err_ovf,
  output logic                  err_unf
);

  localparam logic [2:0] OpNext   = 3'd0;
  localparam logic [2:0] OpJump   = 3'd1;
  localparam logic [2:0] OpBranch = 3'd2;
  localparam logic [2:0] OpCall   = 3'd3;
  localparam logic [2:0] OpRet    = 3'd4;
  localparam logic [2:0] OpWait   = 3'd5;
  localparam logic [2:0] OpHalt   = 3'd6;

  typedef enum logic {StRun, StHalted} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [NUM_CH-1:0]     prev_q;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  push;
  logic                  ch_cur, ch_prev;
  logic                  wait_ok;
  logic                  stack_full, stack_empty;

  assign pc_inc      = pc_q + ADDR_WIDTH'(1);
  assign stack_full  = (cnt_q == CNT_W'(STACK_DEPTH));
  assign stack_empty = (cnt_q == '0);

  // Channel mux; an out-of-range ch_sel matches nothing, so it reads 0 with no edges.
  always_comb begin
    ch_cur  = 1'b0;
    ch_prev = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        ch_cur  = ready_in[i];
        ch_prev = prev_q[i];
      end
    end
  end

  always_comb begin
    if (wait_level) begin
      wait_ok = ch_cur ^ wait_inv;
    end else if (wait_inv) begin
      wait_ok = ~ch_cur & ch_prev;
    end else begin
      wait_ok = ch_cur & ~ch_prev;
    end
  end

  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (cnt_q == CNT_W'(i + 1)) stack_top = stack_q[i];
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    stalled = 1'b0;
    if (state_q == StHalted) begin
      stalled = 1'b1;
    end else begin
      case (op)
        OpJump:   pc_d = target;
        OpBranch: pc_d = cond ? target : pc_inc;
        OpCall: begin
          if (stack_full) begin
            pc_d  = pc_inc;
            ovf_d = 1'b1;
          end else begin
            push  = 1'b1;
            pc_d  = target;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        OpRet: begin
          if (stack_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d  = stack_top;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        OpWait: begin
          if (wait_ok) pc_d = pc_inc;
          else stalled = 1'b1;
        end
        OpHalt: begin
          state_d = StHalted;
          stalled = 1'b1;
        end
        default:  pc_d = pc_inc;  // NEXT and reserved
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      prev_q  <= ready_in;
    end
  end

  // Stack storage needs no reset: entries above cnt_q are never read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (!reset && push && (cnt_q == CNT_W'(i))) stack_q[i] <= pc_inc;
    end
  end

  assign pc        = pc_q;
  assign halted    = (state_q == StHalted);
  assign stack_cnt = cnt_q;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  localparam logic [2:0] NX = 3'd0, JP = 3'd1, BR = 3'd2, CL = 3'd3;
  localparam logic [2:0] RT = 3'd4, WT = 3'd5, HL = 3'd6, RS = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ready_in;
  logic [2:0] op;
  logic [3:0] target;
  logic       cond;
  logic [1:0] ch_sel;
  logic       wait_level;
  logic       wait_inv;
  logic [3:0] pc;
  logic       stalled;
  logic       halted;
  logic [2:0] stack_cnt;
  logic       err_ovf;
  logic       err_unf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .ready_in  (ready_in),
    .op        (op),
    .target    (target),
    .cond      (cond),
    .ch_sel    (ch_sel),
    .wait_level(wait_level),
    .wait_inv  (wait_inv),
    .pc        (pc),
    .stalled   (stalled),
    .halted    (halted),
    .stack_cnt (stack_cnt),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] op;
    logic [3:0] tgt;
    logic       cnd;
    logic [1:0] ch;
    logic       lvl;
    logic       inv;
    logic [3:0] rdy;
    logic       stl;  // expected stalled during the cycle
    logic [3:0] pc;   // expected after the edge
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
    logic       hlt;
  } vec_t;

  function automatic vec_t mk(string n, logic r, logic [2:0] o, logic [3:0] t, logic c,
                              logic [1:0] ch, logic l, logic i, logic [3:0] rd, logic s,
                              logic [3:0] p, logic [2:0] cn, logic ov, logic un, logic h);
    vec_t v;
    v.name = n; v.rst = r; v.op = o; v.tgt = t; v.cnd = c; v.ch = ch; v.lvl = l;
    v.inv = i; v.rdy = rd; v.stl = s; v.pc = p; v.cnt = cn; v.ovf = ov; v.unf = un;
    v.hlt = h;
    return v;
  endfunction

  task automatic check(string tag, string what, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst; op = v.op; target = v.tgt; cond = v.cnd; ch_sel = v.ch;
    wait_level = v.lvl; wait_inv = v.inv; ready_in = v.rdy;
    #1;
    check(v.name, "stalled", int'(stalled), int'(v.stl));
    @(posedge clk);
    #1;
    check(v.name, "pc", int'(pc), int'(v.pc));
    check(v.name, "stack_cnt", int'(stack_cnt), int'(v.cnt));
    check(v.name, "err_ovf", int'(err_ovf), int'(v.ovf));
    check(v.name, "err_unf", int'(err_unf), int'(v.unf));
    check(v.name, "halted", int'(halted), int'(v.hlt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];

    reset = 1'b1; op = NX; target = '0; cond = 1'b0; ch_sel = '0;
    wait_level = 1'b0; wait_inv = 1'b0; ready_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "pc", int'(pc), 0);
    check("reset", "stack_cnt", int'(stack_cnt), 0);
    check("reset", "halted", int'(halted), 0);
    check("reset", "flags", int'({err_ovf, err_unf}), 0);

    // Straight-line and stack vectors, starting at pc=0 after reset
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk("next", 0, NX, 0, 0, 0, 0, 0, 0, 0, 4'((i + 1) % 16), 0, 0, 0, 0));
    tbl.push_back(mk("jump3",     0, JP, 3,  0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0));
    tbl.push_back(mk("call9",     0, CL, 9,  0, 0, 0, 0, 0, 0, 9,  1, 0, 0, 0));
    tbl.push_back(mk("ret4",      0, RT, 0,  0, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0));
    tbl.push_back(mk("jump7",     0, JP, 7,  0, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0));
    tbl.push_back(mk("br_nt",     0, BR, 12, 0, 0, 0, 0, 0, 0, 8,  0, 0, 0, 0));
    tbl.push_back(mk("jump7b",    0, JP, 7,  0, 0, 0, 0, 0, 0, 7,  0, 0, 0, 0));
    tbl.push_back(mk("br_t",      0, BR, 12, 1, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0));
    tbl.push_back(mk("call2",     0, CL, 2,  0, 0, 0, 0, 0, 0, 2,  1, 0, 0, 0));
    tbl.push_back(mk("call5",     0, CL, 5,  0, 0, 0, 0, 0, 0, 5,  2, 0, 0, 0));
    tbl.push_back(mk("call8",     0, CL, 8,  0, 0, 0, 0, 0, 0, 8,  3, 0, 0, 0));
    tbl.push_back(mk("call11",    0, CL, 11, 0, 0, 0, 0, 0, 0, 11, 4, 0, 0, 0));
    tbl.push_back(mk("call_full", 0, CL, 14, 0, 0, 0, 0, 0, 0, 12, 4, 1, 0, 0));
    tbl.push_back(mk("ret_a",     0, RT, 0,  0, 0, 0, 0, 0, 0, 9,  3, 1, 0, 0));
    tbl.push_back(mk("ret_b",     0, RT, 0,  0, 0, 0, 0, 0, 0, 6,  2, 1, 0, 0));
    tbl.push_back(mk("ret_c",     0, RT, 0,  0, 0, 0, 0, 0, 0, 3,  1, 1, 0, 0));
    tbl.push_back(mk("ret_d",     0, RT, 0,  0, 0, 0, 0, 0, 0, 13, 0, 1, 0, 0));
    tbl.push_back(mk("ret_empty", 0, RT, 0,  0, 0, 0, 0, 0, 0, 14, 0, 1, 1, 0));
    tbl.push_back(mk("next_flag", 0, NX, 0,  0, 0, 0, 0, 0, 0, 15, 0, 1, 1, 0));
    tbl.push_back(mk("reserved",  0, RS, 9,  1, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0));
    tbl.push_back(mk("rst_flags", 1, NX, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // WAIT edge mode: ch2 already high when WAIT starts, so only a fresh rise releases it
    apply(mk("w_jump5",   0, JP, 5, 0, 2, 0, 0, 4'b0100, 0, 5, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      apply(mk("w_hi",    0, WT, 0, 0, 2, 0, 0, 4'b0100, 1, 5, 0, 0, 0, 0));
    apply(mk("w_lo",      0, WT, 0, 0, 2, 0, 0, 4'b0000, 1, 5, 0, 0, 0, 0));
    apply(mk("w_rise",    0, WT, 0, 0, 2, 0, 0, 4'b0100, 0, 6, 0, 0, 0, 0));
    apply(mk("w_jump5b",  0, JP, 5, 0, 2, 0, 0, 4'b0000, 0, 5, 0, 0, 0, 0));
    apply(mk("w_lvl_inv", 0, WT, 0, 0, 2, 1, 1, 4'b0000, 0, 6, 0, 0, 0, 0));
    apply(mk("w_next",    0, NX, 0, 0, 2, 0, 0, 4'b0100, 0, 7, 0, 0, 0, 0));
    apply(mk("w_fall_hi", 0, WT, 0, 0, 2, 0, 1, 4'b0100, 1, 7, 0, 0, 0, 0));
    apply(mk("w_fall",    0, WT, 0, 0, 2, 0, 1, 4'b0000, 0, 8, 0, 0, 0, 0));
    apply(mk("w_lvl_oth", 0, WT, 0, 0, 2, 1, 0, 4'b0010, 1, 8, 0, 0, 0, 0));
    apply(mk("w_lvl",     0, WT, 0, 0, 2, 1, 0, 4'b0110, 0, 9, 0, 0, 0, 0));

    // HALT freezes pc and stack; only reset leaves it
    apply(mk("h_call4",   0, CL, 4, 0, 0, 0, 0, 4'b0000, 0, 4, 1, 0, 0, 0));
    apply(mk("h_halt",    0, HL, 0, 0, 0, 0, 0, 4'b0000, 1, 4, 1, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      apply(mk("h_jump1", 0, JP, 1, 0, 0, 0, 0, 4'b0000, 1, 4, 1, 0, 0, 1));
    apply(mk("h_ret",     0, RT, 0, 0, 0, 0, 0, 4'b0000, 1, 4, 1, 0, 0, 1));
    apply(mk("h_reset",   1, JP, 9, 0, 2, 0, 0, 4'b0100, 1, 0, 0, 0, 0, 0));

    // prev cleared by reset: a line held high through reset shows a rise at once
    apply(mk("r_first",   0, WT, 0, 0, 2, 0, 0, 4'b0100, 0, 1, 0, 0, 0, 0));
    apply(mk("r_wait",    0, WT, 0, 0, 2, 0, 0, 4'b0100, 1, 1, 0, 0, 0, 0));
    apply(mk("r_midwait", 1, WT, 0, 0, 2, 0, 0, 4'b0100, 1, 0, 0, 0, 0, 0));
    apply(mk("r_first2",  0, WT, 0, 0, 2, 0, 0, 4'b0100, 0, 1, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
